// File: rtl/demux_1_8.sv
// Registered 1-to-8 demultiplexer: steers i_a onto the o_code line chosen by
// i_sel_code; all other lines are low, so the output is one-hot or zero.
module demux_1_8 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_a,
    input  logic [2:0] i_sel_code,
    output logic [7:0] o_code
);

    logic [7:0] code_d;
    logic [7:0] code_q;

    // Next-state decode: at most one line carries i_a.
    always_comb begin
        code_d = 8'h00;
        if (i_a) begin
            case (i_sel_code)
                3'd0:    code_d = 8'h01;
                3'd1:    code_d = 8'h02;
                3'd2:    code_d = 8'h04;
                3'd3:    code_d = 8'h08;
                3'd4:    code_d = 8'h10;
                3'd5:    code_d = 8'h20;
                3'd6:    code_d = 8'h40;
                3'd7:    code_d = 8'h80;
                default: code_d = 8'h00;
            endcase
        end else begin
            code_d = 8'h00;
        end
    end

    // Output register; reset wins over any input on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            code_q <= 8'h00;
        end else begin
            code_q <= code_d;
        end
    end

    assign o_code = code_q;

endmodule

// File: tb/tb_demux_1_8.sv
// Self-checking bench for demux_1_8: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_demux_1_8;

    logic       clk;
    logic       rst;
    logic       a;
    logic [2:0] sel;
    logic [7:0] code;

    int checks = 0;
    int errors = 0;

    demux_1_8 dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_a        (a),
        .i_sel_code (sel),
        .o_code     (code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the data bit weighted by 2**sel, cleared by reset.
    function automatic logic [7:0] model(input logic r, input logic d, input int s);
        int v;
        v = (r || !d) ? 0 : (1 << s);
        return v[7:0];
    endfunction

    // Drive one input set, let one rising edge pass, return shortly after it.
    task automatic apply(input logic r, input logic d, input logic [2:0] s);
        rst = r;
        a   = d;
        sel = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_v;
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 3'd3);
            checks++;
            if (code !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %02h want 00", i, code);
            end
        end
        apply(1'b0, 1'b1, 3'd3);
        exp_v = model(1'b0, 1'b1, 3);
        checks++;
        if (code !== exp_v || code !== 8'h08) begin
            errors++;
            $display("FAIL reset_release: got %02h want 08", code);
        end
    endtask

    task automatic test_zero_sweep();
        for (int s = 0; s < 8; s++) begin
            apply(1'b0, 1'b0, s[2:0]);
            checks++;
            if (code !== 8'h00) begin
                errors++;
                $display("FAIL zero_sweep sel=%0d: got %02h want 00", s, code);
            end
        end
    endtask

    task automatic test_onehot_sweep();
        logic [7:0] want [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        for (int s = 0; s < 8; s++) begin
            apply(1'b0, 1'b1, s[2:0]);
            checks++;
            if (code !== want[s]) begin
                errors++;
                $display("FAIL onehot_sweep sel=%0d: got %02h want %02h", s, code, want[s]);
            end
        end
    endtask

    task automatic test_counter_sweep();
        int         v;
        logic [7:0] exp_v;
        for (int n = 0; n < 18; n++) begin
            v = n % 16;
            exp_v = model(1'b0, v[3], v % 8);
            apply(1'b0, v[3], v[2:0]);
            checks++;
            if (code !== exp_v) begin
                errors++;
                $display("FAIL counter_sweep n=%0d: got %02h want %02h", n, code, exp_v);
            end
        end
    endtask

    task automatic test_simultaneous();
        apply(1'b0, 1'b1, 3'd7);
        checks++;
        if (code !== 8'h80) begin
            errors++;
            $display("FAIL simul_from: got %02h want 80", code);
        end
        apply(1'b0, 1'b1, 3'd0);
        checks++;
        if (code !== 8'h01) begin
            errors++;
            $display("FAIL simul_to: got %02h want 01", code);
        end
    endtask

    task automatic test_midstream_reset();
        logic       r;
        logic [7:0] exp_v;
        for (int s = 0; s < 8; s++) begin
            r = (s == 5);
            exp_v = model(r, 1'b1, s);
            apply(r, 1'b1, s[2:0]);
            checks++;
            if (code !== exp_v) begin
                errors++;
                $display("FAIL midstream_reset sel=%0d rst=%0b: got %02h want %02h",
                         s, r, code, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic       r;
        logic       d;
        int         s;
        logic [7:0] exp_v;
        for (int n = 0; n < 300; n++) begin
            r = ($urandom_range(15) == 0);
            d = $urandom_range(1);
            s = $urandom_range(7);
            exp_v = model(r, d, s);
            apply(r, d, s[2:0]);
            checks++;
            if (code !== exp_v) begin
                errors++;
                $display("FAIL random n=%0d rst=%0b a=%0b sel=%0d: got %02h want %02h",
                         n, r, d, s, code, exp_v);
            end
            checks++;
            if ($countones(code) > 1) begin
                errors++;
                $display("FAIL onehot_invariant n=%0d: got %02h want at most one bit", n, code);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = 1'b1;
        sel = 3'd3;
        test_reset();
        test_zero_sweep();
        test_onehot_sweep();
        test_counter_sweep();
        test_simultaneous();
        test_midstream_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
